triangle_rasterizer: RTL and testbench
======================================

// Module: triangle_rasterizer
// PURPOSE
//  Receiving end of the triangle_assembler -> rasterizer link. Consumes one screen-space triangle per
//  i_tri_valid pulse and holds o_busy while it works. Scans the triangle's bounding box, clamped to the
//  screen, using incremental edge functions. Emits one fragment (x, y, raw barycentric weights) per
//  covered pixel over a valid/ready stream to the downstream shader/interpolator.
// PARAMETERS
//  SCREEN_W  320  screen width in pixels; valid x is 0..SCREEN_W-1
//  SCREEN_H  240  screen height in pixels; valid y is 0..SCREEN_H-1
//  EW        36   signed width of edge-function accumulators and of o_area
// PORTS
//  i_clk          in   1    clock
//  i_rst          in   1    synchronous, active-high reset
//  i_tri_valid    in   1    single-cycle triangle strobe; sampled only in IDLE
//  o_busy         out  1    high from the cycle after acceptance until the return to IDLE
//  i_x0..i_y2     in   16   signed vertex screen coordinates (V0, V1, V2)
//  i_z0..i_z2     in   8    vertex depth; latched on accept
//  i_u0..i_v2     in   32   vertex texcoords; latched on accept
//  o_tri_z*/u*/v* out  8/32 latched attributes; stable for the whole triangle
//  o_area         out  EW   (x1-x0)(y2-y0)-(x2-x0)(y1-y0); latched; stable for the whole triangle
//  o_frag_valid   out  1    fragment present
//  i_frag_ready   in   1    downstream accepts when valid && ready
//  o_frag_x/y     out  16   unsigned pixel coordinate
//  o_frag_w0/1/2  out  EW   signed edge values E12(p), E20(p), E01(p); w0+w1+w2 == o_area
//  o_tri_done     out  1    1-cycle pulse once every fragment of the triangle has been accepted
//  o_err_drop     out  1    1-cycle pulse when i_tri_valid arrives while not IDLE (triangle ignored)
// BEHAVIOUR
//  Reset: state IDLE. o_busy, o_frag_valid, o_tri_done and o_err_drop are 0. All data outputs are 0.
//  Reset mid-scan aborts immediately: no further fragments, and no o_tri_done pulse.
//  FSM:
//  - IDLE: on i_tri_valid, latch all inputs and go to SETUP. o_busy=1 in the next cycle.
//  - SETUP: compute o_area. Compute the bbox as min/max of x and y, clamped to [0, SCREEN-1].
//    - If o_area<=0, or the bbox is empty (xmin>xmax or ymin>ymax after clamping): go to FINISH.
//    - Otherwise go to INIT.
//  - INIT: for each edge Eab, evaluate A=-(yb-ya), B=(xb-xa) and E at (xmin,ymin) with full multiplies.
//    Save the row-start values, then go to SCAN.
//  - SCAN: row-major order, y outer. One pixel evaluated per cycle whenever !o_frag_valid || i_frag_ready.
//    - Evaluated pixel is covered iff w0>=0 && w1>=0 && w2>=0 (inclusive edges, no top-left rule).
//    - Covered pixel: load o_frag_* and set o_frag_valid=1. Uncovered pixel: o_frag_valid<=0.
//    - Step x: w+=A. At x==xmax: x<=xmin, y+=1, w=rowstart+B.
//    - After the (xmax,ymax) pixel is evaluated, go to FINISH.
//  - FINISH: wait until !o_frag_valid, or the final fragment is accepted.
//    Then pulse o_tri_done, set o_busy=0 and go to IDLE.
//  Latency: strobe at cycle T; first SCAN evaluation at T+3; earliest o_frag_valid at T+4.
//  Stream rules: fragment data is held while valid && !ready. No bubble is inserted when ready stays high.
//  Arithmetic: differences sign-extended to 17b; products 34b; accumulators EW bits, no overflow for
//  16-bit inputs. Pixel coordinates are compared signed against the clamped bbox.
//  A triangle strobed while busy is dropped whole and o_err_drop pulses; the current triangle is unaffected.
// STRUCTURE
//  raster_pkg: SCREEN_W/H defaults, EW, edge_t (logic signed [EW-1:0]), raster_state_t enum, frag_t struct.
//  Sub-module raster_edge_stepper, instantiated 3x: holds one edge's A/B, current value and row-start value.
//  Controls: init, step_x, step_y.
// TESTING
//  1. Tri (0,0),(4,0),(0,4), 64x64 screen, ready=1 -> o_area=16; exactly 15 fragments (x+y<=4).
//     First fragment is (0,0) with w=(16,0,0). o_tri_done 1 pulse; o_busy drops after it.
//  2. Tri (-10,-10),(20,-10),(-10,20), 16x16 screen -> 66 fragments, all with x,y in 0..15.
//     Every fragment satisfies w0+w1+w2 == 900.
//  3. Tri (100,100),(110,100),(100,110), 64x64 screen -> 0 fragments; o_tri_done within 4 cycles of strobe.
//  4. Test 1 with i_frag_ready toggling randomly -> same 15 fragments in the same order.
//     Data stable during stalls; no duplicates and no drops.
//  5. Second strobe while busy -> o_err_drop pulse; first triangle completes intact; no second o_tri_done.
//  6. Assert i_rst after the 5th fragment of test 1 -> o_frag_valid=0 and o_busy=0 next cycle.
//     Next triangle runs normally.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared types and arithmetic helpers for the triangle rasterizer.
// Edge values and the area share one signed accumulator width.
package raster_pkg;

    localparam int SCREEN_W_DEF = 320;
    localparam int SCREEN_H_DEF = 240;
    localparam int EW_DEF       = 36;

    typedef logic signed [EW_DEF-1:0] edge_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_INIT,
        ST_SCAN,
        ST_FINISH
    } raster_state_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        edge_t       w0;
        edge_t       w1;
        edge_t       w2;
    } frag_t;

    // (a1-a0)*(b1-b0): 17-bit differences, exact 34-bit signed product
    function automatic logic signed [33:0] diff_mul(input logic signed [15:0] a1, a0, b1, b0);
        logic signed [16:0] da;
        logic signed [16:0] db;
        da = 17'(a1) - 17'(a0);
        db = 17'(b1) - 17'(b0);
        return 34'(da) * 34'(db);
    endfunction

    function automatic logic signed [15:0] min3(input logic signed [15:0] a, b, c);
        logic signed [15:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [15:0] max3(input logic signed [15:0] a, b, c);
        logic signed [15:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

endpackage

// File: rtl/triangle_rasterizer_if.sv
// Triangle-in / fragment-out link between the assembler, the rasterizer and the shader.
// Signal prefixes are from the rasterizer's point of view.
interface triangle_rasterizer_if #(
    parameter int EW = raster_pkg::EW_DEF
);
    logic                 i_tri_valid;
    logic signed [15:0]   i_x0, i_y0, i_x1, i_y1, i_x2, i_y2;
    logic [7:0]           i_z0, i_z1, i_z2;
    logic [31:0]          i_u0, i_v0, i_u1, i_v1, i_u2, i_v2;
    logic                 o_busy;
    logic [7:0]           o_tri_z0, o_tri_z1, o_tri_z2;
    logic [31:0]          o_tri_u0, o_tri_v0, o_tri_u1, o_tri_v1, o_tri_u2, o_tri_v2;
    logic signed [EW-1:0] o_area;
    logic                 o_frag_valid;
    logic                 i_frag_ready;
    logic [15:0]          o_frag_x, o_frag_y;
    logic signed [EW-1:0] o_frag_w0, o_frag_w1, o_frag_w2;
    logic                 o_tri_done;
    logic                 o_err_drop;

    modport slave (
        input  i_tri_valid, i_x0, i_y0, i_x1, i_y1, i_x2, i_y2,
               i_z0, i_z1, i_z2, i_u0, i_v0, i_u1, i_v1, i_u2, i_v2, i_frag_ready,
        output o_busy, o_tri_z0, o_tri_z1, o_tri_z2,
               o_tri_u0, o_tri_v0, o_tri_u1, o_tri_v1, o_tri_u2, o_tri_v2,
               o_area, o_frag_valid, o_frag_x, o_frag_y,
               o_frag_w0, o_frag_w1, o_frag_w2, o_tri_done, o_err_drop
    );

    modport master (
        output i_tri_valid, i_x0, i_y0, i_x1, i_y1, i_x2, i_y2,
               i_z0, i_z1, i_z2, i_u0, i_v0, i_u1, i_v1, i_u2, i_v2, i_frag_ready,
        input  o_busy, o_tri_z0, o_tri_z1, o_tri_z2,
               o_tri_u0, o_tri_v0, o_tri_u1, o_tri_v1, o_tri_u2, o_tri_v2,
               o_area, o_frag_valid, o_frag_x, o_frag_y,
               o_frag_w0, o_frag_w1, o_frag_w2, o_tri_done, o_err_drop
    );
endinterface

// File: rtl/raster_edge_stepper.sv
// One incremental edge function E(p) = A*(px-xa) + B*(py-ya), A = ya-yb, B = xb-xa.
// Evaluated exactly at the scan origin, then stepped by +A per pixel and +B per row.
module raster_edge_stepper
    import raster_pkg::*;
#(
    parameter int EW = EW_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_init,
    input  logic                 i_step_x,
    input  logic                 i_step_y,
    input  logic signed [15:0]   i_xa,
    input  logic signed [15:0]   i_ya,
    input  logic signed [15:0]   i_xb,
    input  logic signed [15:0]   i_yb,
    input  logic signed [15:0]   i_px,
    input  logic signed [15:0]   i_py,
    output logic signed [EW-1:0] o_w
);
    logic signed [EW-1:0] r_a;
    logic signed [EW-1:0] r_b;
    logic signed [EW-1:0] r_w;
    logic signed [EW-1:0] r_row;

    logic signed [16:0]   w_a;
    logic signed [16:0]   w_b;
    logic signed [EW-1:0] w_e;

    assign w_a = 17'(i_ya) - 17'(i_yb);
    assign w_b = 17'(i_xb) - 17'(i_xa);
    assign w_e = EW'(diff_mul(i_ya, i_yb, i_px, i_xa)) + EW'(diff_mul(i_xb, i_xa, i_py, i_ya));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_w   <= '0;
            r_row <= '0;
        end else if (i_init) begin
            r_a   <= EW'(w_a);
            r_b   <= EW'(w_b);
            r_w   <= w_e;
            r_row <= w_e;
        end else if (i_step_y) begin
            r_w   <= r_row + r_b;
            r_row <= r_row + r_b;
        end else if (i_step_x) begin
            r_w   <= r_w + r_a;
        end
    end

    assign o_w = r_w;
endmodule

// File: rtl/triangle_rasterizer.sv
// Bounding-box scan rasterizer: one pixel evaluated per cycle, covered pixels
// streamed out with their raw edge values over a valid/ready link.
module triangle_rasterizer
    import raster_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int EW       = EW_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    triangle_rasterizer_if.slave bus
);
    localparam logic signed [15:0] XLIM = 16'(SCREEN_W - 1);
    localparam logic signed [15:0] YLIM = 16'(SCREEN_H - 1);

    raster_state_t        r_state;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_drop;
    logic signed [15:0]   r_vx [3];
    logic signed [15:0]   r_vy [3];
    logic [7:0]           r_tri_z [3];
    logic [31:0]          r_tri_u [3];
    logic [31:0]          r_tri_v [3];
    logic signed [EW-1:0] r_area;
    logic signed [15:0]   r_xmin, r_xmax, r_ymin, r_ymax;
    logic signed [15:0]   r_px, r_py;
    logic                 r_fvalid;
    logic [15:0]          r_fx, r_fy;
    logic signed [EW-1:0] r_fw [3];

    logic signed [EW-1:0] w_area;
    logic signed [15:0]   w_xmin, w_xmax, w_ymin, w_ymax;
    logic signed [EW-1:0] w_w [3];
    logic                 w_adv, w_cov, w_at_xmax, w_at_ymax;
    logic                 w_init, w_step_x, w_step_y;

    // Low bound clamps to 0 and high bound to the screen edge independently, so an
    // off-screen box comes out with min > max and is rejected as empty.
    always_comb begin
        w_area = EW'(diff_mul(r_vx[1], r_vx[0], r_vy[2], r_vy[0]))
               - EW'(diff_mul(r_vx[2], r_vx[0], r_vy[1], r_vy[0]));
        w_xmin = min3(r_vx[0], r_vx[1], r_vx[2]);
        w_xmax = max3(r_vx[0], r_vx[1], r_vx[2]);
        w_ymin = min3(r_vy[0], r_vy[1], r_vy[2]);
        w_ymax = max3(r_vy[0], r_vy[1], r_vy[2]);
        if (w_xmin < 16'sd0) w_xmin = 16'sd0;
        if (w_ymin < 16'sd0) w_ymin = 16'sd0;
        if (w_xmax > XLIM)   w_xmax = XLIM;
        if (w_ymax > YLIM)   w_ymax = YLIM;
    end

    assign w_adv     = !r_fvalid || bus.i_frag_ready;
    assign w_cov     = !w_w[0][EW-1] && !w_w[1][EW-1] && !w_w[2][EW-1];
    assign w_at_xmax = (r_px == r_xmax);
    assign w_at_ymax = (r_py == r_ymax);
    assign w_init    = (r_state == ST_INIT);
    assign w_step_x  = (r_state == ST_SCAN) && w_adv && !w_at_xmax;
    assign w_step_y  = (r_state == ST_SCAN) && w_adv && w_at_xmax && !w_at_ymax;

    // Edge gi is the edge opposite vertex gi: E12, E20, E01.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_edge
            raster_edge_stepper #(.EW(EW)) u_edge (
                .i_clk    (i_clk),
                .i_rst    (i_rst),
                .i_init   (w_init),
                .i_step_x (w_step_x),
                .i_step_y (w_step_y),
                .i_xa     (r_vx[(gi + 1) % 3]),
                .i_ya     (r_vy[(gi + 1) % 3]),
                .i_xb     (r_vx[(gi + 2) % 3]),
                .i_yb     (r_vy[(gi + 2) % 3]),
                .i_px     (r_xmin),
                .i_py     (r_ymin),
                .o_w      (w_w[gi])
            );
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_drop   <= 1'b0;
            r_area   <= '0;
            r_xmin   <= '0;
            r_xmax   <= '0;
            r_ymin   <= '0;
            r_ymax   <= '0;
            r_px     <= '0;
            r_py     <= '0;
            r_fvalid <= 1'b0;
            r_fx     <= '0;
            r_fy     <= '0;
            for (int k = 0; k < 3; k++) begin
                r_vx[k]    <= '0;
                r_vy[k]    <= '0;
                r_tri_z[k] <= '0;
                r_tri_u[k] <= '0;
                r_tri_v[k] <= '0;
                r_fw[k]    <= '0;
            end
        end else begin
            r_done <= 1'b0;
            r_drop <= (r_state != ST_IDLE) && bus.i_tri_valid;
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_tri_valid) begin
                        r_vx[0]    <= bus.i_x0;
                        r_vy[0]    <= bus.i_y0;
                        r_vx[1]    <= bus.i_x1;
                        r_vy[1]    <= bus.i_y1;
                        r_vx[2]    <= bus.i_x2;
                        r_vy[2]    <= bus.i_y2;
                        r_tri_z[0] <= bus.i_z0;
                        r_tri_z[1] <= bus.i_z1;
                        r_tri_z[2] <= bus.i_z2;
                        r_tri_u[0] <= bus.i_u0;
                        r_tri_u[1] <= bus.i_u1;
                        r_tri_u[2] <= bus.i_u2;
                        r_tri_v[0] <= bus.i_v0;
                        r_tri_v[1] <= bus.i_v1;
                        r_tri_v[2] <= bus.i_v2;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_area <= w_area;
                    r_xmin <= w_xmin;
                    r_xmax <= w_xmax;
                    r_ymin <= w_ymin;
                    r_ymax <= w_ymax;
                    if (w_area <= 0 || w_xmin > w_xmax || w_ymin > w_ymax)
                        r_state <= ST_FINISH;
                    else
                        r_state <= ST_INIT;
                end
                ST_INIT: begin
                    r_px    <= r_xmin;
                    r_py    <= r_ymin;
                    r_state <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (w_adv) begin
                        r_fvalid <= w_cov;
                        if (w_cov) begin
                            r_fx <= r_px;
                            r_fy <= r_py;
                            for (int k = 0; k < 3; k++) r_fw[k] <= w_w[k];
                        end
                        if (!w_at_xmax) begin
                            r_px <= r_px + 16'sd1;
                        end else if (!w_at_ymax) begin
                            r_px <= r_xmin;
                            r_py <= r_py + 16'sd1;
                        end else begin
                            r_state <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    if (w_adv) begin
                        r_fvalid <= 1'b0;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_busy       = r_busy;
    assign bus.o_tri_done   = r_done;
    assign bus.o_err_drop   = r_drop;
    assign bus.o_area       = r_area;
    assign bus.o_frag_valid = r_fvalid;
    assign bus.o_frag_x     = r_fx;
    assign bus.o_frag_y     = r_fy;
    assign bus.o_frag_w0    = r_fw[0];
    assign bus.o_frag_w1    = r_fw[1];
    assign bus.o_frag_w2    = r_fw[2];
    assign bus.o_tri_z0     = r_tri_z[0];
    assign bus.o_tri_z1     = r_tri_z[1];
    assign bus.o_tri_z2     = r_tri_z[2];
    assign bus.o_tri_u0     = r_tri_u[0];
    assign bus.o_tri_u1     = r_tri_u[1];
    assign bus.o_tri_u2     = r_tri_u[2];
    assign bus.o_tri_v0     = r_tri_v[0];
    assign bus.o_tri_v1     = r_tri_v[1];
    assign bus.o_tri_v2     = r_tri_v[2];
endmodule

// File: tb/tb_triangle_rasterizer.sv
// Directed bench for triangle_rasterizer: a 64x64 and a 16x16 instance share one clock;
// accepted fragments are captured at the falling edge and compared to hand-derived lists.
module tb_triangle_rasterizer;
    import raster_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    triangle_rasterizer_if #(.EW(EW_DEF)) bus64 ();
    triangle_rasterizer_if #(.EW(EW_DEF)) bus16 ();

    triangle_rasterizer #(.SCREEN_W(64), .SCREEN_H(64), .EW(EW_DEF)) dut64 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus64)
    );
    triangle_rasterizer #(.SCREEN_W(16), .SCREEN_H(16), .EW(EW_DEF)) dut16 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus16)
    );

    int n_tests = 0;
    int n_fail  = 0;

    frag_t q64[$];
    frag_t q16[$];
    frag_t exp1[$];
    int    done64 = 0, done16 = 0, drop64 = 0, stall64 = 0;
    logic  prev_stall64 = 1'b0;
    frag_t prev64 = '0;
    frag_t cur64, cur16;

    function automatic frag_t mk(input logic [15:0] x, y, input edge_t w0, w1, w2);
        frag_t f;
        f.x = x; f.y = y; f.w0 = w0; f.w1 = w1; f.w2 = w2;
        return f;
    endfunction

    assign cur64 = mk(bus64.o_frag_x, bus64.o_frag_y, bus64.o_frag_w0, bus64.o_frag_w1, bus64.o_frag_w2);
    assign cur16 = mk(bus16.o_frag_x, bus16.o_frag_y, bus16.o_frag_w0, bus16.o_frag_w1, bus16.o_frag_w2);

    // Handshake monitor: a fragment counts as delivered when valid && ready at the edge.
    always @(negedge clk) begin
        if (bus64.o_frag_valid && bus64.i_frag_ready) q64.push_back(cur64);
        if (bus16.o_frag_valid && bus16.i_frag_ready) q16.push_back(cur16);
        if (prev_stall64 && !rst && !(bus64.o_frag_valid && cur64 === prev64)) stall64 <= stall64 + 1;
        prev_stall64 <= bus64.o_frag_valid && !bus64.i_frag_ready;
        prev64       <= cur64;
        if (bus64.o_tri_done) done64 <= done64 + 1;
        if (bus16.o_tri_done) done16 <= done16 + 1;
        if (bus64.o_err_drop) drop64 <= drop64 + 1;
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic strobe(input bit sel16, input logic signed [15:0] x0, y0, x1, y1, x2, y2,
                          input logic [7:0] zb);
        @(posedge clk); #1;
        if (sel16) begin
            bus16.i_x0 = x0; bus16.i_y0 = y0; bus16.i_x1 = x1;
            bus16.i_y1 = y1; bus16.i_x2 = x2; bus16.i_y2 = y2;
            bus16.i_tri_valid = 1'b1;
        end else begin
            bus64.i_x0 = x0; bus64.i_y0 = y0; bus64.i_x1 = x1;
            bus64.i_y1 = y1; bus64.i_x2 = x2; bus64.i_y2 = y2;
            bus64.i_z0 = zb; bus64.i_z1 = zb + 8'd1; bus64.i_z2 = zb + 8'd2;
            bus64.i_u0 = {zb, 24'd0}; bus64.i_u1 = {zb, 24'd1}; bus64.i_u2 = {zb, 24'd2};
            bus64.i_v0 = ~{zb, 24'd0}; bus64.i_v1 = ~{zb, 24'd1}; bus64.i_v2 = ~{zb, 24'd2};
            bus64.i_tri_valid = 1'b1;
        end
        @(posedge clk); #1;
        bus64.i_tri_valid = 1'b0;
        bus16.i_tri_valid = 1'b0;
    endtask

    task automatic wait_done(input bit sel16, input int target, input bit rnd, input string tag);
        int k;
        k = 0;
        while (((sel16 ? done16 : done64) < target) && k < 3000) begin
            @(posedge clk); #1;
            if (rnd) bus64.i_frag_ready = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            k++;
        end
        chk(tag, 160'(k < 3000), 160'(1));
        @(posedge clk); #1;
        bus64.i_frag_ready = 1'b1;
    endtask

    task automatic cmp_list1(input int base, input string tag);
        frag_t g;
        chk({tag, "_count"}, 160'(q64.size() - base), 160'(15));
        for (int i = 0; i < 15; i++) begin
            g = (base + i < q64.size()) ? q64[base + i] : '0;
            chk($sformatf("%s_frag%0d", tag, i), g, exp1[i]);
        end
    endtask

    initial begin
        int    b, b16, d, k, bad;
        bit    found;
        frag_t g;

        bus64.i_tri_valid = 0; bus64.i_frag_ready = 1;
        bus64.i_x0 = 0; bus64.i_y0 = 0; bus64.i_x1 = 0; bus64.i_y1 = 0; bus64.i_x2 = 0; bus64.i_y2 = 0;
        bus64.i_z0 = 0; bus64.i_z1 = 0; bus64.i_z2 = 0;
        bus64.i_u0 = 0; bus64.i_u1 = 0; bus64.i_u2 = 0; bus64.i_v0 = 0; bus64.i_v1 = 0; bus64.i_v2 = 0;
        bus16.i_tri_valid = 0; bus16.i_frag_ready = 1;
        bus16.i_x0 = 0; bus16.i_y0 = 0; bus16.i_x1 = 0; bus16.i_y1 = 0; bus16.i_x2 = 0; bus16.i_y2 = 0;
        bus16.i_z0 = 0; bus16.i_z1 = 0; bus16.i_z2 = 0;
        bus16.i_u0 = 0; bus16.i_u1 = 0; bus16.i_u2 = 0; bus16.i_v0 = 0; bus16.i_v1 = 0; bus16.i_v2 = 0;

        // Tri (0,0),(4,0),(0,4): w0 = 16-4x-4y, w1 = 4x, w2 = 4y, covered iff x+y <= 4
        for (int y = 0; y <= 4; y++)
            for (int x = 0; x <= 4; x++)
                if (x + y <= 4)
                    exp1.push_back(mk(16'(x), 16'(y), edge_t'(16 - 4 * x - 4 * y),
                                      edge_t'(4 * x), edge_t'(4 * y)));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_busy",  bus64.o_busy, 0);
        chk("rst_valid", bus64.o_frag_valid, 0);
        chk("rst_done",  bus64.o_tri_done, 0);
        chk("rst_drop",  bus64.o_err_drop, 0);
        chk("rst_area",  bus64.o_area, 0);
        chk("rst_fx",    bus64.o_frag_x, 0);
        chk("rst_z0",    bus64.o_tri_z0, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Test 1: basic triangle, latency, attributes
        b = q64.size(); d = done64;
        strobe(0, 0, 0, 4, 0, 0, 4, 8'h11);
        @(negedge clk); #1;
        chk("t1_busy_next", bus64.o_busy, 1);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("t1_valid_T3", bus64.o_frag_valid, 0);
        @(negedge clk); #1;
        chk("t1_valid_T4", bus64.o_frag_valid, 1);
        chk("t1_first", cur64, mk(0, 0, 16, 0, 0));
        chk("t1_area", bus64.o_area, 16);
        wait_done(0, d + 1, 0, "t1_timeout");
        cmp_list1(b, "t1");
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("t1_done_once", done64, d + 1);
        chk("t1_busy_low", bus64.o_busy, 0);
        chk("t1_z1", bus64.o_tri_z1, 8'h12);
        chk("t1_v2", bus64.o_tri_v2, 32'hEEFF_FFFD);

        // Test 2: triangle larger than the 16x16 screen
        b16 = q16.size();
        strobe(1, -10, -10, 20, -10, -10, 20, 8'h00);
        wait_done(1, done16 + 1, 0, "t2_timeout");
        chk("t2_count", q16.size() - b16, 66);
        chk("t2_area", bus16.o_area, 900);
        g = (q16.size() > b16) ? q16[b16] : '0;
        chk("t2_first", g, mk(0, 0, 300, 300, 300));
        g = (q16.size() >= b16 + 66) ? q16[b16 + 65] : '0;
        chk("t2_last", g, mk(0, 10, 0, 300, 600));
        bad = 0;
        for (int i = b16; i < q16.size(); i++)
            if (q16[i].w0 + q16[i].w1 + q16[i].w2 != edge_t'(900) || q16[i].x > 15 || q16[i].y > 15)
                bad++;
        chk("t2_sum_range_bad", bad, 0);

        // Test 3: completely off-screen
        b = q64.size();
        strobe(0, 100, 100, 110, 100, 100, 110, 8'h33);
        found = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (bus64.o_tri_done) found = 1;
        end
        chk("t3_done_fast", found, 1);
        chk("t3_count", q64.size() - b, 0);

        // Test 4: random backpressure
        repeat (2) @(posedge clk);
        b = q64.size(); d = done64;
        strobe(0, 0, 0, 4, 0, 0, 4, 8'h44);
        wait_done(0, d + 1, 1, "t4_timeout");
        cmp_list1(b, "t4");
        chk("t4_stall_hold", stall64, 0);

        // Test 5: strobe while busy is dropped
        b = q64.size(); d = done64; k = drop64;
        strobe(0, 0, 0, 4, 0, 0, 4, 8'h20);
        repeat (2) @(posedge clk);
        strobe(0, 0, 0, 8, 0, 0, 8, 8'h60);
        wait_done(0, d + 1, 0, "t5_timeout");
        cmp_list1(b, "t5");
        chk("t5_drop", drop64, k + 1);
        chk("t5_z0_kept", bus64.o_tri_z0, 8'h20);
        repeat (30) @(posedge clk);
        @(negedge clk); #1;
        chk("t5_no_2nd_done", done64, d + 1);

        // Test 6: reset after the 5th fragment
        b = q64.size(); d = done64;
        strobe(0, 0, 0, 4, 0, 0, 4, 8'h55);
        k = 0;
        while (q64.size() < b + 5 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        chk("t6_reach5", 160'(k < 300), 160'(1));
        rst = 1'b1;
        bus64.i_frag_ready = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        chk("t6_valid_rst", bus64.o_frag_valid, 0);
        chk("t6_busy_rst", bus64.o_busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus64.i_frag_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk); #1;
        chk("t6_count5", q64.size() - b, 5);
        chk("t6_no_done", done64, d);
        b = q64.size();
        strobe(0, 0, 0, 4, 0, 0, 4, 8'h66);
        wait_done(0, d + 1, 0, "t6_timeout");
        cmp_list1(b, "t6_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
